cache_mem_init_bank: RTL and testbench

// - Next-gen cache data/tag storage bank: 1R1W synchronous RAM with a byte-enable write port.
// - Built-in init engine that (re)fills every entry after reset or on request.
// - Read pipeline has configurable latency and a read-valid strobe.
// - Sits under the cache controller; one instance per tag or data way.

---
 rtl/cache_mem_init_bank.sv | 153 +++++++++++++++
 tb/tb_cache_mem_init_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_init_bank.sv
// 1R1W byte-enable storage bank with built-in init engine and 1/2-cycle read pipeline.
// Optional macro CACHE_MEM_FWD_EN selects write-first same-address read (default read-first).
module cache_mem_init_bank #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int INIT_ZERO  = 0,
    parameter int RD_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_start,
    output logic                      init_busy,
    output logic                      ready,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wbe,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic                      rd_valid,
    output logic [DATA_WIDTH-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   count;
    logic [ADDR_WIDTH:0]     count_inc;
    logic [DATA_WIDTH-1:0]   init_val;
    logic                    init_we;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_be;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    v1;
    logic [DATA_WIDTH-1:0]   d1;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] nw,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Counter is widened by one bit so entry DEPTH-1 gets DEPTH, not 0.
    always_comb begin
        count_inc = {1'b0, count} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        init_val  = '0;
        if (INIT_ZERO == 0) init_val = DATA_WIDTH'(count_inc);
    end

    assign init_we = (state == S_INIT) && !init_start;
    assign wr_acc  = wr_en && ready;
    assign rd_acc  = rd_en && ready;

    always_comb begin
        mem_we    = init_we || wr_acc;
        mem_addr  = waddr;
        mem_wdata = wdata;
        mem_be    = wbe;
        if (init_we) begin
            mem_addr  = count;
            mem_wdata = init_val;
            mem_be    = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            count     <= '0;
            init_busy <= 1'b1;
            ready     <= 1'b0;
        end else if (init_start) begin
            state     <= S_INIT;
            count     <= '0;
            init_busy <= 1'b1;
            ready     <= 1'b0;
        end else if (state == S_INIT) begin
            count <= count + ADDR_WIDTH'(1);
            if (&count) begin
                state     <= S_RUN;
                init_busy <= 1'b0;
                ready     <= 1'b1;
            end
        end
    end

    // Storage array is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_be);
    end

    always_comb begin
        rd_word = mem[raddr];
`ifdef CACHE_MEM_FWD_EN
        if (wr_acc && (waddr == raddr)) rd_word = merge(rd_word, wdata, wbe);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= rd_word;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rd_valid = v1;
            assign rdata    = d1;
        end else if (RD_LAT == 2) begin : g_lat2
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end
            assign rd_valid = v2;
            assign rdata    = d2;
        end else begin : g_bad_lat
            $error("cache_mem_init_bank: RD_LAT must be 1 or 2");
            assign rd_valid = 1'b0;
            assign rdata    = '0;
        end
    endgenerate

endmodule

// File: tb/tb_cache_mem_init_bank.sv
// Directed bench: three banks (RD_LAT=1, RD_LAT=2, INIT_ZERO=1) driven by shared inputs.
module tb_cache_mem_init_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_start;
    logic        wr_en;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        rd_en;
    logic [3:0]  raddr;

    logic        busy_a, ready_a, val_a;
    logic [31:0] dat_a;
    logic        busy_b, ready_b, val_b;
    logic [31:0] dat_b;
    logic        busy_z, ready_z, val_z;
    logic [31:0] dat_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_mem_init_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_ZERO(0), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .init_busy(busy_a), .ready(ready_a),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd_en(rd_en), .raddr(raddr), .rd_valid(val_a), .rdata(dat_a)
    );

    cache_mem_init_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_ZERO(0), .RD_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .init_busy(busy_b), .ready(ready_b),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd_en(rd_en), .raddr(raddr), .rd_valid(val_b), .rdata(dat_b)
    );

    cache_mem_init_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_ZERO(1), .RD_LAT(1)) u_z (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .init_busy(busy_z), .ready(ready_z),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd_en(rd_en), .raddr(raddr), .rd_valid(val_z), .rdata(dat_z)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic [3:0]  ra;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        init_start = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wbe        = 4'h0;
    endtask

    // Counts edges until init_busy on the RD_LAT=1 bank falls.
    task automatic wait_init(output int n);
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic        saw_valid;
        logic [31:0] fwd_exp;

`ifdef CACHE_MEM_FWD_EN
        fwd_exp = 32'h12345678;
`else
        fwd_exp = 32'h00000008;
`endif
        tbl[0]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5,  1'b1, 32'h00000006};
        tbl[1]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h00000006};
        tbl[2]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'h5, 1'b0, 4'd0,  1'b0, 32'h00000006};
        tbl[3]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'h00BB00DD};
        tbl[4]  = '{1'b1, 4'd7, 32'h12345678, 4'hF, 1'b1, 4'd7,  1'b1, fwd_exp};
        tbl[5]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7,  1'b1, 32'h12345678};
        tbl[6]  = '{1'b1, 4'd9, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd9,  1'b1, 32'h0000000A};
        tbl[7]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd9,  1'b1, 32'h0000000A};
        tbl[8]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd15, 1'b1, 32'h00000010};
        tbl[9]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0,  1'b1, 32'h00000001};
        tbl[10] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h00000001};
        tbl[11] = '{1'b1, 4'd0, 32'h11223344, 4'h8, 1'b0, 4'd0,  1'b0, 32'h00000001};
        tbl[12] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0,  1'b1, 32'h11000001};
        tbl[13] = '{1'b1, 4'd1, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0,  1'b0, 32'h11000001};

        rst_n = 1'b0;
        idle();
        waddr = '0;
        wdata = '0;
        raddr = '0;
        tick();
        tick();
        chk("reset busy", 32'(busy_a), 32'd1);
        chk("reset ready", 32'(ready_a), 32'd0);
        chk("reset rd_valid", 32'(val_a), 32'd0);
        chk("reset rdata", dat_a, 32'h0);

        // Requests issued during init must be dropped.
        rst_n     = 1'b1;
        wr_en     = 1'b1;
        waddr     = 4'd2;
        wdata     = 32'hDEADBEEF;
        wbe       = 4'hF;
        rd_en     = 1'b1;
        raddr     = 4'd5;
        saw_valid = 1'b0;
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
            saw_valid = saw_valid | val_a | val_b | val_z;
        end
        idle();
        chk("init cycles", 32'(n), 32'd16);
        chk("no rd_valid in init", 32'(saw_valid), 32'd0);
        chk("ready after init", 32'(ready_a), 32'd1);
        chk("zero bank busy", 32'(busy_z), 32'd0);

        rd_en = 1'b1;
        raddr = 4'd2;
        tick();
        chk("rd2 valid", 32'(val_a), 32'd1);
        chk("rd2 data", dat_a, 32'h00000003);
        chk("rd2 zero data", dat_z, 32'h0);
        chk("rd2 lat2 valid early", 32'(val_b), 32'd0);
        raddr = 4'd15;
        tick();
        chk("rd15 data", dat_a, 32'h00000010);
        chk("rd15 zero valid", 32'(val_z), 32'd1);
        chk("rd15 zero data", dat_z, 32'h0);
        chk("rd2 lat2 valid", 32'(val_b), 32'd1);
        chk("rd2 lat2 data", dat_b, 32'h00000003);
        idle();

        for (int k = 0; k < 14; k++) begin
            wr_en = tbl[k].wr;
            waddr = tbl[k].wa;
            wdata = tbl[k].wd;
            wbe   = tbl[k].be;
            rd_en = tbl[k].rd;
            raddr = tbl[k].ra;
            tick();
            chk($sformatf("vec%0d valid", k), 32'(val_a), 32'(tbl[k].ev));
            chk($sformatf("vec%0d data", k), dat_a, tbl[k].ed);
            if (k > 0) begin
                chk($sformatf("vec%0d lat2 valid", k), 32'(val_b), 32'(tbl[k-1].ev));
                chk($sformatf("vec%0d lat2 data", k), dat_b, tbl[k-1].ed);
            end
        end
        idle();

        // Read accepted on the same edge that restarts init.
        rd_en      = 1'b1;
        raddr      = 4'd1;
        init_start = 1'b1;
        tick();
        idle();
        chk("reinit rd valid", 32'(val_a), 32'd1);
        chk("reinit rd data", dat_a, 32'hFFFFFFFF);
        chk("reinit busy", 32'(busy_a), 32'd1);
        chk("reinit ready", 32'(ready_a), 32'd0);
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
            if (n == 1) begin
                chk("reinit lat2 valid", 32'(val_b), 32'd1);
                chk("reinit lat2 data", dat_b, 32'hFFFFFFFF);
            end
        end
        chk("reinit cycles", 32'(n), 32'd16);
        rd_en = 1'b1;
        raddr = 4'd1;
        tick();
        idle();
        chk("addr1 after reinit", dat_a, 32'h00000002);

        // Async reset at init counter 9.
        rd_en      = 1'b1;
        raddr      = 4'd3;
        init_start = 1'b1;
        tick();
        idle();
        chk("pre-reset rd data", dat_a, 32'h00000004);
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(val_a), 32'd0);
        chk("async rst data", dat_a, 32'h0);
        chk("async rst lat2 data", dat_b, 32'h0);
        chk("async rst busy", 32'(busy_a), 32'd1);
        chk("async rst ready", 32'(ready_a), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_init(n);
        chk("post-reset init cycles", 32'(n), 32'd16);
        rd_en = 1'b1;
        raddr = 4'd3;
        tick();
        idle();
        chk("addr3 after reset", dat_a, 32'h00000004);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
